// File: rtl/alpha_trim_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alpha_trim_pkg                                                   |
// | Shared defaults, width derivations and FSM encodings.            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package alpha_trim_pkg;

    function automatic int atm_keep(input int dn, input int trim);
        return dn - 2 * trim;
    endfunction

    function automatic int atm_sumw(input int dn, input int dw);
        return dw + $clog2(dn);
    endfunction

    function automatic int atm_seqw(input int dn);
        return $clog2(dn);
    endfunction

    localparam int c_DN_DEFAULT   = 25;
    localparam int c_DW_DEFAULT   = 8;
    localparam int c_TRIM_DEFAULT = 5;
    localparam int c_KEEP_DEFAULT = atm_keep(c_DN_DEFAULT, c_TRIM_DEFAULT);
    localparam int c_SUMW_DEFAULT = atm_sumw(c_DN_DEFAULT, c_DW_DEFAULT);
    localparam int c_SEQW_DEFAULT = atm_seqw(c_DN_DEFAULT);

    localparam int         c_STATE_W  = 4;
    localparam logic [3:0] c_ST_IDLE  = 4'b0001;
    localparam logic [3:0] c_ST_ACCUM = 4'b0010;
    localparam logic [3:0] c_ST_DIV   = 4'b0100;
    localparam logic [3:0] c_ST_DONE  = 4'b1000;

endpackage : alpha_trim_pkg
`default_nettype wire

// File: rtl/atm_seq_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | atm_seq_div                                                      |
// | Restoring serial divider by a constant, one quotient bit/cycle.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module atm_seq_div #(
    parameter int SUMW    = 13,
    parameter int QW      = 8,
    parameter int DIVISOR = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [SUMW-1:0] i_dividend,
    output logic [QW-1:0]   o_quotient,
    output logic            o_done
);
    localparam int            c_CNTW    = $clog2(SUMW + 1);
    localparam logic [SUMW:0] c_DIVISOR = (SUMW + 1)'(DIVISOR);

    logic [SUMW-1:0]   r_rem;
    logic [SUMW-1:0]   r_quo;
    logic [c_CNTW-1:0] r_cnt;
    logic              r_busy;

    logic [SUMW:0]     w_trial;
    logic              w_ge;
    logic [SUMW-1:0]   w_diff;

    // Remainder stays below the divisor, so the difference fits in SUMW bits.
    assign w_trial = {r_rem, r_quo[SUMW-1]};
    assign w_ge    = (w_trial >= c_DIVISOR);
    assign w_diff  = w_trial[SUMW-1:0] - c_DIVISOR[SUMW-1:0];

    assign o_quotient = r_quo[QW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_cnt  <= c_CNTW'(SUMW);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff : w_trial[SUMW-1:0];
                r_quo <= {r_quo[SUMW-2:0], w_ge};
                r_cnt <= r_cnt - c_CNTW'(1);
                if (r_cnt == c_CNTW'(1)) begin
                    r_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule : atm_seq_div
`default_nettype wire

// File: rtl/alpha_trim_mean.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alpha_trim_mean                                                  |
// | Alpha-trimmed mean of a sorted window; ALPHA_TRIM_MEAN_ROUND_EN  |
// | selects round-half-up instead of truncation.                     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module alpha_trim_mean
    import alpha_trim_pkg::*;
#(
    parameter int DN   = c_DN_DEFAULT,
    parameter int DW   = c_DW_DEFAULT,
    parameter int TRIM = c_TRIM_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sort_finish,
    input  logic [DW*DN-1:0]                  data_unsort,
    input  logic [atm_seqw(DN)*DN-1:0]        sequence_sorted,
    output logic [DW-1:0]                     mean_out,
    output logic                              mean_vld,
    output logic                              busy
);
    localparam int DW_sequence = atm_seqw(DN);
    localparam int KEEP        = atm_keep(DN, TRIM);
    localparam int SUMW        = atm_sumw(DN, DW);

    localparam logic [DW_sequence-1:0] c_K_FIRST = DW_sequence'(TRIM);
    localparam logic [DW_sequence-1:0] c_K_LAST  = DW_sequence'(DN - TRIM - 1);

    logic [c_STATE_W-1:0]        r_state;
    logic [c_STATE_W-1:0]        w_state_nxt;
    logic [DW*DN-1:0]            r_data;
    logic [DW_sequence*DN-1:0]   r_seq;
    logic [SUMW-1:0]             r_sum;
    logic [DW_sequence-1:0]      r_k;
    logic                        r_div_start;

    logic                        w_capture;
    logic                        w_accum_en;
    logic                        w_last_add;
    logic                        w_finish;
    logic                        w_div_done;
    logic [DW-1:0]               w_quo;
    logic [SUMW-1:0]             w_dividend;

    logic [DW-1:0]               w_samp [DN];
    logic [DW_sequence-1:0]      w_slot [DN];
    logic [DW_sequence-1:0]      w_idx;
    logic [DW-1:0]               w_pick;
    logic [SUMW-1:0]             w_addend;

    for (genvar gi = 0; gi < DN; gi++) begin : g_unpack
        assign w_samp[gi] = r_data[gi*DW +: DW];
        assign w_slot[gi] = r_seq[gi*DW_sequence +: DW_sequence];
    end

    // Out-of-range sorted indices are treated as zero-valued samples.
    assign w_idx    = w_slot[r_k];
    assign w_pick   = (int'(w_idx) < DN) ? w_samp[w_idx] : '0;
    assign w_addend = {{(SUMW-DW){1'b0}}, w_pick};

`ifdef ALPHA_TRIM_MEAN_ROUND_EN
    assign w_dividend = r_sum + SUMW'(KEEP / 2);
`else
    assign w_dividend = r_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = sort_finish ? c_ST_ACCUM : c_ST_IDLE;
            c_ST_ACCUM: w_state_nxt = (r_k == c_K_LAST) ? c_ST_DIV : c_ST_ACCUM;
            c_ST_DIV:   w_state_nxt = w_div_done ? c_ST_DONE : c_ST_DIV;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture  = 1'b0;
        w_accum_en = 1'b0;
        w_last_add = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            c_ST_IDLE:  w_capture  = sort_finish;
            c_ST_ACCUM: begin
                w_accum_en = 1'b1;
                w_last_add = (r_k == c_K_LAST);
            end
            c_ST_DONE:  w_finish   = 1'b1;
            default:    w_capture  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_seq       <= '0;
            r_sum       <= '0;
            r_k         <= '0;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= w_last_add;
            if (w_capture) begin
                r_data <= data_unsort;
                r_seq  <= sequence_sorted;
                r_sum  <= '0;
                r_k    <= c_K_FIRST;
            end else if (w_accum_en) begin
                r_sum <= r_sum + w_addend;
                r_k   <= r_k + DW_sequence'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_out <= '0;
            mean_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mean_vld <= w_finish;
            if (w_finish) begin
                mean_out <= w_quo;
            end
            if (w_capture) begin
                busy <= 1'b1;
            end else if (w_finish) begin
                busy <= 1'b0;
            end
        end
    end

    atm_seq_div #(
        .SUMW    (SUMW),
        .QW      (DW),
        .DIVISOR (KEEP)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (r_div_start),
        .i_dividend (w_dividend),
        .o_quotient (w_quo),
        .o_done     (w_div_done)
    );

endmodule : alpha_trim_mean
`default_nettype wire
